fetch_pc_gen: RTL and testbench



---
 rtl/core_pkg.sv | 13 +
 rtl/pc_next_sel.sv | 47 ++++
 rtl/fetch_pc_gen.sv | 109 ++++++++++
 tb/tb_fetch_pc_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared front-end types and defaults for the fetch PC generator.
// Optional counters are enabled by defining FETCH_PC_GEN_PERF_EN.
package core_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > redirect > advance, with target masking
// and misalignment detection on the winning redirect target.
module pc_next_sel
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int STEP = 4
) (
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            advance,
  input  logic [XLEN-1:0] pc_inc,
  output logic [XLEN-1:0] pc_d,
  output logic            pc_upd,
  output logic            redir,
  output logic            misal,
  output logic [XLEN-1:0] tgt
);

  localparam logic [XLEN-1:0] LOW = XLEN'(STEP - 1);

  always_comb begin
    pc_d   = pc_inc;
    pc_upd = advance;
    redir  = 1'b0;
    tgt    = '0;
    priority case (1'b1)
      trap_valid: begin
        redir = 1'b1;
        tgt   = trap_addr;
      end
      redirect_valid: begin
        redir = 1'b1;
        tgt   = redirect_addr;
      end
      default: ;
    endcase
    if (redir) begin
      pc_d   = tgt & ~LOW;
      pc_upd = 1'b1;
    end
    misal = redir && ((tgt & LOW) != '0);
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register, RUN/HALT debug FSM and fetch request generation.
// Define FETCH_PC_GEN_PERF_EN to add fetch/redirect counters.
module fetch_pc_gen
  import core_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              STEP         = 4,
  parameter int              COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [XLEN-1:0]    fetch_addr,
  output logic [XLEN-1:0]    pc0,
  output logic [XLEN-1:0]    pc_next,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_addr,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_addr,
  input  logic               halt_req,
  input  logic               resume,
  output logic               halted,
`ifdef FETCH_PC_GEN_PERF_EN
  output logic [COUNT_W-1:0] fetch_count,
  output logic [COUNT_W-1:0] redirect_count,
`endif
  output logic               misaligned_err,
  output logic [XLEN-1:0]    misaligned_addr
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q;
  logic [XLEN-1:0] eaddr_q, eaddr_d;
  logic            pc_upd, redir, misal, advance;
  logic [XLEN-1:0] tgt;

  assign pc0         = pc_q;
  assign fetch_addr  = pc_q;
  assign pc_next     = pc_q + XLEN'(STEP);
  assign halted      = (state_q == HALT);
  assign fetch_valid = (state_q == RUN) && !stall;
  assign advance     = fetch_valid && fetch_ready;

  assign misaligned_err  = err_q;
  assign misaligned_addr = eaddr_q;

  pc_next_sel #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_sel (
    .trap_valid     (trap_valid),
    .trap_addr      (trap_addr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .advance        (advance),
    .pc_inc         (pc_next),
    .pc_d           (pc_d),
    .pc_upd         (pc_upd),
    .redir          (redir),
    .misal          (misal),
    .tgt            (tgt)
  );

  always_comb begin
    state_d = state_q;
    eaddr_d = misal ? tgt : eaddr_q;
    unique case (state_q)
      RUN:     if (halt_req) state_d = HALT;
      HALT:    if (resume)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      err_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= misal;
      eaddr_q <= eaddr_d;
      if (pc_upd) pc_q <= pc_d;
    end
  end

`ifdef FETCH_PC_GEN_PERF_EN
  logic [COUNT_W-1:0] fcnt_q, rcnt_q;

  assign fetch_count    = fcnt_q;
  assign redirect_count = rcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      if (advance && !redir) fcnt_q <= fcnt_q + 1'b1;
      if (redir)             rcnt_q <= rcnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed + random bench for fetch_pc_gen against a behavioural model.
module tb_fetch_pc_gen;

  localparam int          XLEN = 32;
  localparam int          STEP = 4;
  localparam logic [31:0] RV   = 32'h0000_0100;

  logic            clk = 1'b0;
  logic            rst, stall, fetch_ready;
  logic            redirect_valid, trap_valid, halt_req, resume;
  logic [XLEN-1:0] redirect_addr, trap_addr;
  logic            fetch_valid, halted, misaligned_err;
  logic [XLEN-1:0] fetch_addr, pc0, pc_next, misaligned_addr;
`ifdef FETCH_PC_GEN_PERF_EN
  logic [31:0]     fetch_count, redirect_count;
  longint          m_fc, m_rc;
`endif

  longint m_pc, m_eaddr;
  bit     m_halt, m_err;
  int     n_cmp = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;

  fetch_pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .STEP         (STEP),
    .COUNT_W      (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .fetch_addr      (fetch_addr),
    .pc0             (pc0),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .trap_valid      (trap_valid),
    .trap_addr       (trap_addr),
    .halt_req        (halt_req),
    .resume          (resume),
    .halted          (halted),
`ifdef FETCH_PC_GEN_PERF_EN
    .fetch_count     (fetch_count),
    .redirect_count  (redirect_count),
`endif
    .misaligned_err  (misaligned_err),
    .misaligned_addr (misaligned_addr)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: sequential PC arithmetic modulo 2^32, alignment by remainder.
  task automatic model();
    longint tgt;
    bit     fv, hit;
    if (rst) begin
      m_pc = RV; m_halt = 0; m_err = 0; m_eaddr = 0;
`ifdef FETCH_PC_GEN_PERF_EN
      m_fc = 0; m_rc = 0;
`endif
      return;
    end
    fv  = !m_halt && !stall;
    hit = trap_valid || redirect_valid;
    tgt = trap_valid ? longint'(trap_addr) : longint'(redirect_addr);
    if (hit) begin
      m_pc  = tgt - (tgt % STEP);
      m_err = (tgt % STEP) != 0;
      if (m_err) m_eaddr = tgt;
`ifdef FETCH_PC_GEN_PERF_EN
      m_rc = (m_rc + 1) % (64'd1 << 32);
`endif
    end else begin
      m_err = 0;
      if (fv && fetch_ready) begin
        m_pc = (m_pc + STEP) % (64'd1 << 32);
`ifdef FETCH_PC_GEN_PERF_EN
        m_fc = (m_fc + 1) % (64'd1 << 32);
`endif
      end
    end
    if (!m_halt && halt_req) m_halt = 1;
    else if (m_halt && resume) m_halt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    check("pc0", pc0, m_pc);
    check("fetch_addr", fetch_addr, m_pc);
    check("pc_next", pc_next, (m_pc + STEP) % (64'd1 << 32));
    check("halted", halted, m_halt);
    check("fetch_valid", fetch_valid, !m_halt && !stall);
    check("mis_err", misaligned_err, m_err);
    check("mis_addr", misaligned_addr, m_eaddr);
`ifdef FETCH_PC_GEN_PERF_EN
    check("fetch_count", fetch_count, m_fc);
    check("redirect_count", redirect_count, m_rc);
`endif
  endtask

  task automatic idle();
    rst = 0; stall = 0; fetch_ready = 1;
    redirect_valid = 0; trap_valid = 0; halt_req = 0; resume = 0;
    redirect_addr = '0; trap_addr = '0;
  endtask

  task automatic go(input logic [31:0] a);
    redirect_valid = 1; redirect_addr = a;
    tick();
    redirect_valid = 0;
  endtask

  initial begin
    m_pc = 0; m_halt = 0; m_err = 0; m_eaddr = 0;
`ifdef FETCH_PC_GEN_PERF_EN
    m_fc = 0; m_rc = 0;
`endif
    idle();
    rst = 1;
    tick();
    check("rst_pc", pc0, 32'h100);
    check("rst_fv", fetch_valid, 1);
    check("rst_err", misaligned_err, 0);
    rst = 0;
    tick();
    check("seq1", pc0, 32'h104);
    tick();
    check("seq2", pc0, 32'h108);

    go(32'h20);
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_addr", fetch_addr, 32'h20);
    end
    fetch_ready = 1;
    tick();
    check("ready_adv", pc0, 32'h24);

    trap_valid = 1; trap_addr = 32'h80;
    redirect_valid = 1; redirect_addr = 32'h40; stall = 1;
    tick();
    check("trap_prio", pc0, 32'h80);
    idle();

    go(32'h42);
    check("mis_pc", pc0, 32'h40);
    check("mis_pulse", misaligned_err, 1);
    check("mis_addr_c", misaligned_addr, 32'h42);
    tick();
    check("mis_drop", misaligned_err, 0);
    check("mis_keep", misaligned_addr, 32'h42);

    fetch_ready = 0;
    go(32'h10);
    halt_req = 1;
    tick();
    halt_req = 0; fetch_ready = 1;
    check("halt_h", halted, 1);
    check("halt_fv", fetch_valid, 0);
    check("halt_pc", pc0, 32'h10);
    go(32'h200);
    check("halt_redir", pc0, 32'h200);
    check("halt_still", halted, 1);
    resume = 1;
    tick();
    resume = 0;
    check("resume_h", halted, 0);
    check("resume_pc", pc0, 32'h200);
    tick();
    check("resume_adv", pc0, 32'h204);

    go(32'hFFFF_FFFC);
    tick();
    check("wrap", pc0, 32'h0);

`ifdef FETCH_PC_GEN_PERF_EN
    rst = 1;
    tick();
    rst = 0;
    check("cnt_rst", fetch_count, 0);
    tick();
    check("cnt_one", fetch_count, 1);
`endif

    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(49) == 0);
      stall          = ($urandom_range(3) == 0);
      fetch_ready    = ($urandom_range(3) != 0);
      trap_valid     = ($urandom_range(9) == 0);
      redirect_valid = ($urandom_range(5) == 0);
      halt_req       = ($urandom_range(14) == 0);
      resume         = ($urandom_range(4) == 0);
      trap_addr      = $urandom;
      redirect_addr  = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
